// File: rtl/latch_capture_reader.sv
// rtl/latch_capture_reader.sv - clocked reader that captures one settled word per latch close
module latch_capture_reader #(
   parameter int WIDTH         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_latch_en,
   input  logic [WIDTH-1:0] i_latch_q,
   input  logic             i_data_ready,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_data_valid,
   output logic             o_overrun,
   output logic [7:0]       o_capture_count
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_OPEN,
      S_SETTLE,
      S_PRESENT
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_en_sync;
   logic [WIDTH-1:0]       r_q_sync [SYNC_STAGES];
   logic [WIDTH-1:0]       r_q_prev;
   logic                   r_en_prev;
   logic [CW-1:0]          r_stable_cnt;

   logic                   w_en_s;
   logic [WIDTH-1:0]       w_q_s;
   logic                   w_q_eq;
   logic                   w_accept;
   logic                   w_en_rise;

   assign w_en_s    = r_en_sync[SYNC_STAGES-1];
   assign w_q_s     = r_q_sync[SYNC_STAGES-1];
   assign w_q_eq    = (w_q_s == r_q_prev);
   assign w_accept  = o_data_valid & i_data_ready;
   assign w_en_rise = w_en_s & ~r_en_prev;

   // Bring the asynchronous enable and data into the clock domain; keep one-cycle history of each
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_en_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_q_sync[i] <= '0;
         end
         r_q_prev  <= '0;
         r_en_prev <= 1'b0;
      end else begin
         r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], i_latch_en};
         r_q_sync[0] <= i_latch_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_q_sync[i] <= r_q_sync[i-1];
         end
         r_q_prev  <= w_q_s;
         r_en_prev <= w_en_s;
      end
   end

   // Track open/close of the latch, wait for stable data, then hold the word until accepted
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state         <= S_IDLE;
         r_stable_cnt    <= '0;
         o_data_out      <= '0;
         o_data_valid    <= 1'b0;
         o_overrun       <= 1'b0;
         o_capture_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_en_s) begin
                  r_state <= S_OPEN;
               end
            end
            S_OPEN: begin
               if (!w_en_s) begin
                  r_state      <= S_SETTLE;
                  r_stable_cnt <= '0;
               end
            end
            S_SETTLE: begin
               if (w_en_s) begin
                  // Latch reopened before the data settled: drop this close event
                  r_state <= S_OPEN;
               end else if (!w_q_eq) begin
                  r_stable_cnt <= '0;
               end else if (r_stable_cnt == CNT_LAST) begin
                  o_data_out   <= w_q_s;
                  o_data_valid <= 1'b1;
                  r_state      <= S_PRESENT;
               end else begin
                  r_stable_cnt <= r_stable_cnt + 1'b1;
               end
            end
            S_PRESENT: begin
               if (w_accept) begin
                  o_data_valid    <= 1'b0;
                  o_capture_count <= o_capture_count + 8'd1;
                  r_state         <= w_en_s ? S_OPEN : S_IDLE;
               end else if (w_en_rise) begin
                  // Writer started a new word while ours is still unread
                  o_overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_capture_reader.sv
// tb/tb_latch_capture_reader.sv - scoreboard bench for latch_capture_reader
module tb_latch_capture_reader;

   logic       clk;
   logic       reset_n;
   logic       latch_en;
   logic [7:0] latch_q;
   logic       data_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic       overrun;
   logic [7:0] capture_count;

   int         checks;
   int         failures;
   logic [7:0] exp_q[$];
   logic [7:0] exp_count;

   latch_capture_reader #(
      .WIDTH(8),
      .SYNC_STAGES(2),
      .STABLE_CYCLES(2)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_latch_en     (latch_en),
      .i_latch_q      (latch_q),
      .i_data_ready   (data_ready),
      .o_data_out     (data_out),
      .o_data_valid   (data_valid),
      .o_overrun      (overrun),
      .o_capture_count(capture_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted word is compared with the oldest expected word
   always @(negedge clk) begin
      if (reset_n && data_valid && data_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", data_out);
         end else begin
            check("word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!data_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!data_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drop;
      int n;
      n = 0;
      while (data_valid && n < 40) begin
         tick();
         n++;
      end
      if (data_valid) check("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic open_latch(input logic [7:0] q, input int n);
      latch_en = 1'b1;
      latch_q  = q;
      repeat (n) tick();
   endtask

   // Close the latch with ready high and wait for the word to be taken
   task automatic capture(input logic [7:0] q);
      int cyc;
      open_latch(q, 2);
      exp_q.push_back(q);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      wait_valid(cyc);
      wait_drop();
   endtask

   initial begin
      int cyc;
      checks     = 0;
      failures   = 0;
      exp_count  = 8'd0;
      reset_n    = 1'b0;
      latch_en   = 1'b1;
      latch_q    = 8'hFF;
      data_ready = 1'b1;

      // 1: reset held with the latch open and data present
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_valid", {31'd0, data_valid}, 32'd0);
         check("rst_data", {24'd0, data_out}, 32'd0);
         check("rst_overrun", {31'd0, overrun}, 32'd0);
         check("rst_count", {24'd0, capture_count}, 32'd0);
      end
      reset_n = 1'b1;

      // 2: basic capture, minimum latency, one-cycle pulse with ready high
      open_latch(8'hA5, 4);
      exp_q.push_back(8'hA5);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      wait_valid(cyc);
      check("basic_latency", cyc, 32'd5);
      check("basic_data", {24'd0, data_out}, 32'h0000_00A5);
      tick();
      check("basic_pulse", {31'd0, data_valid}, 32'd0);
      check("basic_count", {24'd0, capture_count}, 32'd1);

      // 3: data still moving after close; only the final word is taken
      open_latch(8'h10, 4);
      exp_q.push_back(8'h12);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      tick();
      latch_q = 8'h11;
      tick();
      latch_q = 8'h12;
      wait_valid(cyc);
      check("settle_latency", cyc + 2, 32'd7);
      wait_drop();

      // 4: reopen during settling gives no word; the next close does
      open_latch(8'h77, 4);
      latch_en = 1'b0;
      tick();
      tick();
      open_latch(8'h3C, 8);
      check("abort_no_valid", {31'd0, data_valid}, 32'd0);
      exp_q.push_back(8'h3C);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      wait_valid(cyc);
      check("abort_data", {24'd0, data_out}, 32'h0000_003C);
      wait_drop();
      check("abort_count", {24'd0, capture_count}, {24'd0, exp_count});
      check("pre_overrun", {31'd0, overrun}, 32'd0);

      // 5: backpressure, reopen while presenting sets overrun, data frozen
      data_ready = 1'b0;
      open_latch(8'h55, 3);
      exp_q.push_back(8'h55);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      wait_valid(cyc);
      open_latch(8'hAA, 5);
      check("bp_valid", {31'd0, data_valid}, 32'd1);
      check("bp_data", {24'd0, data_out}, 32'h0000_0055);
      check("bp_overrun", {31'd0, overrun}, 32'd1);
      data_ready = 1'b1;
      wait_drop();
      tick();
      tick();
      exp_q.push_back(8'hAA);
      latch_en = 1'b0;
      exp_count = exp_count + 8'd1;
      wait_valid(cyc);
      check("reopen_data", {24'd0, data_out}, 32'h0000_00AA);
      wait_drop();
      check("overrun_sticky", {31'd0, overrun}, 32'd1);
      check("ovr_count", {24'd0, capture_count}, {24'd0, exp_count});

      // 6: run the count through its wrap
      for (int i = 0; i < 252; i++) begin
         capture(8'(i) ^ 8'h5A);
         check("wrap_count", {24'd0, capture_count}, {24'd0, exp_count});
      end
      check("wrap_zero_model", {24'd0, capture_count}, 32'd1);

      // Asynchronous reset while a word is presented
      data_ready = 1'b0;
      open_latch(8'hC3, 2);
      exp_q.push_back(8'hC3);
      latch_en = 1'b0;
      wait_valid(cyc);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_valid", {31'd0, data_valid}, 32'd0);
      check("async_count", {24'd0, capture_count}, 32'd0);
      check("async_data", {24'd0, data_out}, 32'd0);
      check("async_overrun", {31'd0, overrun}, 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      tick();
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      check("post_reset_valid", {31'd0, data_valid}, 32'd0);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
